// File: rtl/gmii_tx_pkg.sv
// Shared definitions for the GMII transmit path.
//
// Contents:
//   PREAMBLE_BYTE, SFD_BYTE   - bytes sent ahead of every frame
//   CRC_INIT, CRC_POLY_REFL   - IEEE 802.3 CRC-32 (reflected form)
//   MIN_FRAME                 - minimum frame length before FCS (DA..payload+pad)
//   gmii_tx_state_e           - framer FSM states
//
// Build option: GMII_TX_PAD_EN adds the PAD state used for short-frame padding.
package gmii_tx_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
    localparam logic [10:0] MIN_FRAME     = 11'd60;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
`ifdef GMII_TX_PAD_EN
        ST_PAD,
`endif
        ST_FCS,
        ST_IFG
    } gmii_tx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational 8-bit-parallel CRC-32 next-state function (reflected,
// polynomial 0xEDB88320). Data bits are consumed LSB first, matching the
// order Ethernet puts bits on the wire. Shared with the RX FCS checker.
//
// Ports:
//   crc      in  32  current CRC register
//   data     in  8   byte to fold in
//   crc_next out 32  CRC register after the byte
module crc32_d8
    import gmii_tx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// Transmit-side Ethernet framer feeding the GMII TX inputs of the PCS/PMA.
// Takes raw frame bytes (DA..payload) and puts preamble, SFD, payload,
// optional zero padding, FCS and inter-frame gap on GMII, one byte per clock.
//
// Build option: GMII_TX_PAD_EN - when defined, frames shorter than 60 bytes
// are zero-padded to 60 before the FCS; when undefined the upstream block
// guarantees the minimum length and FCS follows the last byte directly.
//
// Parameters:
//   IFG_BYTES  idle cycles after the last FCS byte (12..255)
//   PRE_BYTES  number of 0x55 preamble bytes before the SFD
//   CNT_W      width of the saturating frame / underrun counters
//
// Ports:
//   GMII_CLK      in   125 MHz clock
//   RESET_IN      in   synchronous active-high reset
//   TX_DATA       in   frame byte
//   TX_VALID      in   TX_DATA valid
//   TX_LAST       in   last byte of the frame (qualified by TX_VALID)
//   TX_READY      out  byte accepted when TX_VALID && TX_READY
//   GMII_TXD      out  registered GMII data
//   GMII_TX_EN    out  registered GMII enable
//   GMII_TX_ER    out  registered GMII error
//   TX_BUSY       out  high whenever the FSM is not IDLE
//   FRAME_CNT     out  frames completed with FCS
//   UNDERRUN_CNT  out  frames aborted by underrun
//
// Handshake: a byte transfers on a rising edge where TX_VALID and TX_READY
// are both high. TX_READY depends only on the FSM state (high only in DATA),
// never on TX_VALID. Once a frame has started, TX_VALID low in DATA is an
// underrun, not a stall.
module gmii_tx_framer
    import gmii_tx_pkg::*;
#(
    parameter int IFG_BYTES = 12,
    parameter int PRE_BYTES = 7,
    parameter int CNT_W     = 16
) (
    input  logic             GMII_CLK,
    input  logic             RESET_IN,
    input  logic [7:0]       TX_DATA,
    input  logic             TX_VALID,
    input  logic             TX_LAST,
    output logic             TX_READY,
    output logic [7:0]       GMII_TXD,
    output logic             GMII_TX_EN,
    output logic             GMII_TX_ER,
    output logic             TX_BUSY,
    output logic [CNT_W-1:0] FRAME_CNT,
    output logic [CNT_W-1:0] UNDERRUN_CNT
);

    localparam logic [7:0]       IFG_LAST = 8'(IFG_BYTES);
    localparam logic [7:0]       PRE_LAST = 8'(PRE_BYTES);
    localparam logic [10:0]      BYTE_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    gmii_tx_state_e   state_q, state_d;
    logic [10:0]      byte_cnt_q, byte_cnt_d;
    // Shared step counter: preamble bytes in PRE, FCS byte index in FCS,
    // gap cycles in IFG. Only one of those is live at a time.
    logic [7:0]       step_cnt_q, step_cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic [7:0]       txd_q, txd_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_er_q, tx_er_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;

    logic [7:0]       crc_in;
    logic [31:0]      crc_next;
    logic [31:0]      fcs_word;
    logic [10:0]      byte_cnt_inc;

    // Pad bytes are zero; only DATA feeds real bytes into the CRC.
    assign crc_in       = (state_q == ST_DATA) ? TX_DATA : 8'h00;
    assign fcs_word     = ~crc_q;
    assign byte_cnt_inc = (byte_cnt_q == BYTE_MAX) ? byte_cnt_q : byte_cnt_q + 11'd1;

    crc32_d8 u_crc32_d8 (
        .crc      (crc_q),
        .data     (crc_in),
        .crc_next (crc_next)
    );

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        step_cnt_d     = step_cnt_q;
        crc_d          = crc_q;
        txd_d          = 8'h00;
        tx_en_d        = 1'b0;
        tx_er_d        = 1'b0;
        frame_cnt_d    = frame_cnt_q;
        underrun_cnt_d = underrun_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (TX_VALID) begin
                    // First preamble byte is issued here, so PRE counts from 1.
                    state_d    = ST_PRE;
                    step_cnt_d = 8'd1;
                    byte_cnt_d = 11'd0;
                    crc_d      = CRC_INIT;
                    txd_d      = PREAMBLE_BYTE;
                    tx_en_d    = 1'b1;
                end
            end

            ST_PRE: begin
                tx_en_d = 1'b1;
                if (step_cnt_q < PRE_LAST) begin
                    txd_d      = PREAMBLE_BYTE;
                    step_cnt_d = step_cnt_q + 8'd1;
                end else begin
                    // SFD goes out while DATA (and TX_READY) is already active,
                    // so the first data byte lands right behind it.
                    txd_d   = SFD_BYTE;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                tx_en_d = 1'b1;
                if (TX_VALID) begin
                    txd_d      = TX_DATA;
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_inc;
                    if (TX_LAST) begin
                        state_d    = ST_FCS;
                        step_cnt_d = 8'd0;
`ifdef GMII_TX_PAD_EN
                        if (byte_cnt_inc < MIN_FRAME) begin
                            state_d = ST_PAD;
                        end
`endif
                    end
                end else begin
                    // Underrun: one errored byte tells the far end to drop it.
                    txd_d          = 8'h00;
                    tx_er_d        = 1'b1;
                    state_d        = ST_IFG;
                    step_cnt_d     = 8'd0;
                    underrun_cnt_d = (underrun_cnt_q == CNT_MAX) ? underrun_cnt_q
                                                                 : underrun_cnt_q + CNT_W'(1);
                end
            end

`ifdef GMII_TX_PAD_EN
            ST_PAD: begin
                tx_en_d    = 1'b1;
                txd_d      = 8'h00;
                crc_d      = crc_next;
                byte_cnt_d = byte_cnt_inc;
                if (byte_cnt_inc >= MIN_FRAME) begin
                    state_d    = ST_FCS;
                    step_cnt_d = 8'd0;
                end
            end
`endif

            ST_FCS: begin
                tx_en_d = 1'b1;
                case (step_cnt_q[1:0])
                    2'd0:    txd_d = fcs_word[7:0];
                    2'd1:    txd_d = fcs_word[15:8];
                    2'd2:    txd_d = fcs_word[23:16];
                    default: txd_d = fcs_word[31:24];
                endcase
                if (step_cnt_q[1:0] == 2'd3) begin
                    state_d     = ST_IFG;
                    step_cnt_d  = 8'd0;
                    frame_cnt_d = (frame_cnt_q == CNT_MAX) ? frame_cnt_q
                                                           : frame_cnt_q + CNT_W'(1);
                end else begin
                    step_cnt_d = step_cnt_q + 8'd1;
                end
            end

            ST_IFG: begin
                // Entered while the last byte is still on the wire, so the
                // state lasts IFG_BYTES+1 cycles to give IFG_BYTES idle
                // output cycles before IDLE.
                if (step_cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    step_cnt_d = step_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge GMII_CLK) begin
        if (RESET_IN) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= 11'd0;
            step_cnt_q     <= 8'd0;
            crc_q          <= CRC_INIT;
            txd_q          <= 8'h00;
            tx_en_q        <= 1'b0;
            tx_er_q        <= 1'b0;
            frame_cnt_q    <= '0;
            underrun_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            step_cnt_q     <= step_cnt_d;
            crc_q          <= crc_d;
            txd_q          <= txd_d;
            tx_en_q        <= tx_en_d;
            tx_er_q        <= tx_er_d;
            frame_cnt_q    <= frame_cnt_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign TX_READY     = (state_q == ST_DATA);
    assign TX_BUSY      = (state_q != ST_IDLE);
    assign GMII_TXD     = txd_q;
    assign GMII_TX_EN   = tx_en_q;
    assign GMII_TX_ER   = tx_er_q;
    assign FRAME_CNT    = frame_cnt_q;
    assign UNDERRUN_CNT = underrun_cnt_q;

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- Transmit-side Ethernet framer that drives the GMII TX inputs of the 1000BASE-X/SGMII PCS/PMA wrapper.
- Accepts a raw frame byte stream (DA through payload) from the SiTCP-side TX path over a valid/ready handshake.
- Emits preamble, SFD, payload, optional padding, IEEE 802.3 FCS and inter-frame gap on GMII at one byte per GMII_CLK.

Parameters:
- IFG_BYTES, 12, idle cycles after last FCS byte (legal range 12..255).
- PRE_BYTES, 7, number of 0x55 preamble bytes before SFD 0xD5.
- CNT_W, 16, width of frame and underrun counters (saturating).

Ports:
- GMII_CLK  in  1  125 MHz GMII clock; sole clock.
- RESET_IN  in  1  synchronous, active-high reset.
- TX_DATA  in  8  frame byte.
- TX_VALID  in  1  TX_DATA valid.
- TX_LAST  in  1  marks last frame byte; qualified by TX_VALID.
- TX_READY  out  1  byte accepted when TX_VALID && TX_READY.
- GMII_TXD  out  8  to PCS.
- GMII_TX_EN  out  1  to PCS.
- GMII_TX_ER  out  1  to PCS.
- TX_BUSY  out  1  high in every state except IDLE.
- FRAME_CNT  out  CNT_W  frames completed with good FCS.
- UNDERRUN_CNT  out  CNT_W  frames aborted by underrun.

Behaviour:
- Reset: GMII_TXD=0x00, GMII_TX_EN=0, GMII_TX_ER=0, TX_READY=0, TX_BUSY=0, both counters=0, FSM=IDLE, CRC=0xFFFFFFFF. Reset mid-frame aborts immediately; no FCS or TX_ER is emitted.
- All GMII outputs are registered. Output cycle N reflects the decision made in cycle N-1.
- FSM states: IDLE, PRE, DATA, PAD, FCS, IFG.
- IDLE: TX_READY=0. When TX_VALID=1, go to PRE. The first preamble byte appears on GMII one cycle later.
- PRE: emit PRE_BYTES x 0x55, then 0xD5 (SFD). TX_READY rises coincident with the SFD output cycle so that the first data byte follows the SFD with no gap.
- DATA: TX_READY=1. Each accepted byte goes to GMII_TXD, increments the byte count, and updates the CRC.
  - Accepted byte with TX_LAST=1: go to PAD if the byte count is < 60 and padding is enabled; otherwise go to FCS. TX_READY drops in the same cycle.
  - Underrun (TX_VALID=0 in DATA): output one byte with GMII_TX_EN=1, GMII_TX_ER=1, GMII_TXD=0x00. Then go to IFG. UNDERRUN_CNT increments; FRAME_CNT does not. This follows the 802.3 error-propagation convention.
- PAD: emit 0x00 (CRC-included) until the byte count reaches 60, then go to FCS.
- FCS: emit ~CRC as 4 bytes, least significant byte first. CRC is CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF. On the 4th byte, increment FRAME_CNT and go to IFG.
- IFG: GMII_TX_EN=0, GMII_TXD=0x00 for exactly IFG_BYTES cycles, then IDLE. A TX_VALID held high during IFG starts the next frame on the first IDLE cycle. Back-to-back frames therefore have a period of frame_len + 8 + IFG_BYTES + 1 cycles.
- Byte counter: 11 bits, saturates at 2047. There is no maximum-length enforcement.
- Counters saturate at all-ones and never wrap.
- TX_LAST seen while in IDLE marks a 1-byte frame: the first accepted byte is the last.

Optional Feature:
- Macro: GMII_TX_PAD_EN.
- Defined: short frames are zero-padded to 60 bytes before FCS (minimum 64-byte frame on the wire).
- Undefined: the PAD state and its logic are removed. FCS follows the last byte directly; the upstream block guarantees the minimum length.

Decomposition:
- Shared package gmii_tx_pkg holds:
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_INIT=0xFFFFFFFF, CRC_POLY_REFL=0xEDB88320, MIN_FRAME=60;
  - the FSM state enum.
- One sub-module: crc32_d8, a combinational 8-bit-parallel CRC-32 next-state function (in: crc[31:0], data[7:0]; out: crc_next). It is reused by the future RX FCS checker.

Test Plan:
- Pad undefined; send ASCII "123456789" (9 bytes, TX_LAST on 0x39) -> GMII_TX_EN high for 21 cycles: 7x0x55, 0xD5, the 9 bytes, then 0x26,0x39,0xF4,0xCB. FRAME_CNT=1.
- GMII_TX_PAD_EN defined; send a 20-byte frame -> 40 bytes of 0x00 after the payload, then FCS. TX_EN high 72 cycles; FCS matches a software CRC over 60 bytes.
- Two 64-byte frames with TX_VALID held continuously -> TX_EN low for exactly 12 cycles between frames plus 1 IDLE cycle. FRAME_CNT=2.
- Drop TX_VALID after byte 30 of a 100-byte frame -> one cycle with TX_EN=1, TX_ER=1. No FCS; TX_EN=0 next. UNDERRUN_CNT=1, FRAME_CNT unchanged.
- Assert RESET_IN for 1 cycle during FCS byte 2 -> next cycle all GMII outputs 0, counters 0, TX_BUSY=0. A following frame transmits correctly.
- IFG_BYTES=20, single frame -> TX_BUSY stays high exactly 20 cycles after TX_EN falls.
